// File: rtl/obstacle_pkg.sv
// obstacle_pkg: display geometry, coordinate width, obstacle type encoding and LFSR constants shared by the obstacle lane
package obstacle_pkg;
  localparam int CW = 12;
  localparam int D_WIDTH = 640;
  localparam int D_HEIGHT = 480;
  localparam int BORDER = 40;
  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} obs_type_e;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16,14,13,11); ports clk, rst_n (sync, loads seed), en (advance), q (state)
module lfsr16 import obstacle_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_DEF_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= SEED;
    else if (en) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0);
endmodule

// File: rtl/obstacle_lane.sv
// obstacle_lane: N_OBS scrolling obstacle slots with LFSR spawning; ports i_clk, i_rst_n, i_ani_stb, i_animate, i_spawn_en, i_speed, i_slowness in; o_active, o_type, o_x1/o_x2/o_y1/o_y2 (12 bits per slot), o_pass out
module obstacle_lane import obstacle_pkg::*; #(
  parameter int N_OBS = 3,
  parameter int H_WIDTH = 20,
  parameter int H_HEIGHT_LOW = 80,
  parameter int H_HEIGHT_HIGH = 20,
  parameter int Y_HIGH = 300,
  parameter int BORDER = obstacle_pkg::BORDER,
  parameter int D_WIDTH = obstacle_pkg::D_WIDTH,
  parameter int D_HEIGHT = obstacle_pkg::D_HEIGHT,
  parameter int SPD_W = 4,
  parameter int SLOW_W = 4,
  parameter int MIN_GAP = 200,
  parameter int GAP_RAND_W = 7,
  parameter int HIGH_EN = 1,
  parameter logic [15:0] LFSR_SEED = LFSR_DEF_SEED
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ani_stb,
  input  logic                  i_animate,
  input  logic                  i_spawn_en,
  input  logic [SPD_W-1:0]      i_speed,
  input  logic [SLOW_W-1:0]     i_slowness,
  output logic [N_OBS-1:0]      o_active,
  output logic [N_OBS-1:0]      o_type,
  output logic [CW*N_OBS-1:0]   o_x1,
  output logic [CW*N_OBS-1:0]   o_x2,
  output logic [CW*N_OBS-1:0]   o_y1,
  output logic [CW*N_OBS-1:0]   o_y2,
  output logic                  o_pass
);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? LFSR_DEF_SEED : LFSR_SEED;
  localparam logic [CW-1:0] HW = CW'(H_WIDTH);
  localparam logic [CW-1:0] X_SPAWN = CW'(D_WIDTH - H_WIDTH);
  localparam logic [CW-1:0] Y_LOW_C = CW'(D_HEIGHT - BORDER - H_HEIGHT_LOW);
  localparam logic [CW-1:0] Y_HIGH_C = CW'(Y_HIGH);
  localparam logic [CW-1:0] HL = CW'(H_HEIGHT_LOW);
  localparam logic [CW-1:0] HH = CW'(H_HEIGHT_HIGH);
  localparam logic [CW-1:0] GAP_MASK = CW'((1 << GAP_RAND_W) - 1);
  if (MIN_GAP < 2 * H_WIDTH) begin : g_gap_check
    $error("obstacle_lane: MIN_GAP must be at least 2*H_WIDTH");
  end
  logic [SLOW_W-1:0] slow_cnt;
  logic [CW-1:0] gap_cnt, gap_target, gap_next, spd;
  logic [CW:0] gap_sum;
  logic [15:0] lfsr;
  logic tick, spawn, new_type, unused;
  logic [N_OBS-1:0] active, typ, retire, sel;
  logic [CW-1:0] x [N_OBS];
  logic [CW-1:0] x1_r [N_OBS];
  logic [CW-1:0] x2_r [N_OBS];
  logic [CW-1:0] y1_r [N_OBS];
  logic [CW-1:0] y2_r [N_OBS];
  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(i_clk), .rst_n(i_rst_n), .en(tick), .q(lfsr));
  assign unused = ^lfsr[14:CW];
  // sel is the lowest free slot as a one-hot: free & -free, with -free == active + 1
  always_comb begin
    spd = CW'(i_speed);
    tick = i_animate && i_ani_stb && (slow_cnt == i_slowness);
    gap_sum = {1'b0, gap_cnt} + {1'b0, spd};
    gap_next = gap_sum[CW] ? '1 : gap_sum[CW-1:0];
    sel = ~active & (active + N_OBS'(1));
    spawn = tick && i_spawn_en && (gap_next >= gap_target) && (|sel);
    new_type = (HIGH_EN != 0) ? lfsr[15] : LOW;
    for (int k = 0; k < N_OBS; k++) retire[k] = active[k] && (x[k] < HW + spd);
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      slow_cnt <= '0;
      gap_cnt <= '1;
      gap_target <= CW'(MIN_GAP);
      o_pass <= 1'b0;
    end else begin
      if (i_animate && i_ani_stb) slow_cnt <= tick ? '0 : slow_cnt + SLOW_W'(1);
      o_pass <= tick && (|retire);
      if (tick) gap_cnt <= spawn ? '0 : gap_next;
      if (spawn) gap_target <= CW'(MIN_GAP) + (lfsr[CW-1:0] & GAP_MASK);
    end
  for (genvar k = 0; k < N_OBS; k++) begin : g_slot
    logic load, act_n, typ_n;
    logic [CW-1:0] x_n, y_c, h;
    always_comb begin
      load = spawn && sel[k];
      act_n = tick ? (load || (active[k] && !retire[k])) : active[k];
      typ_n = load ? new_type : typ[k];
      x_n = load ? X_SPAWN : (tick && active[k] && !retire[k]) ? x[k] - spd : x[k];
      y_c = (typ_n == HIGH) ? Y_HIGH_C : Y_LOW_C;
      h = (typ_n == HIGH) ? HH : HL;
    end
    always_ff @(posedge i_clk)
      if (!i_rst_n) begin
        active[k] <= 1'b0;
        typ[k] <= LOW;
        x[k] <= '0;
        x1_r[k] <= '0;
        x2_r[k] <= '0;
        y1_r[k] <= '0;
        y2_r[k] <= '0;
      end else begin
        active[k] <= act_n;
        typ[k] <= typ_n;
        x[k] <= x_n;
        x1_r[k] <= act_n ? x_n - HW : '0;
        x2_r[k] <= act_n ? x_n + HW : '0;
        y1_r[k] <= act_n ? y_c - h : '0;
        y2_r[k] <= act_n ? y_c + h : '0;
      end
  end
  always_comb begin
    o_active = active;
    o_type = typ;
    o_x1 = '0;
    o_x2 = '0;
    o_y1 = '0;
    o_y2 = '0;
    for (int k = 0; k < N_OBS; k++) begin
      o_x1[CW*k +: CW] = x1_r[k];
      o_x2[CW*k +: CW] = x2_r[k];
      o_y1[CW*k +: CW] = y1_r[k];
      o_y2[CW*k +: CW] = y2_r[k];
    end
  end
endmodule

// File: tb/tb_obstacle_lane.sv
// tb_obstacle_lane: directed self-checking bench for obstacle_lane (3-slot fixed-gap lane and 2-slot typed lane)
module tb_obstacle_lane;
  logic clk = 0, rst_n = 0, ani_stb = 0, animate = 0, spawn_en = 0;
  logic [3:0] speed = 0, slowness = 0;
  logic [2:0] a_act, a_typ;
  logic [35:0] a_x1, a_x2, a_y1, a_y2;
  logic a_pass;
  logic [1:0] b_act, b_typ;
  logic [23:0] b_x1, b_x2, b_y1, b_y2;
  logic b_pass;
  int n_cmp = 0, n_err = 0;
  obstacle_lane #(.N_OBS(3), .GAP_RAND_W(0), .HIGH_EN(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate), .i_spawn_en(spawn_en),
    .i_speed(speed), .i_slowness(slowness), .o_active(a_act), .o_type(a_typ),
    .o_x1(a_x1), .o_x2(a_x2), .o_y1(a_y1), .o_y2(a_y2), .o_pass(a_pass));
  obstacle_lane #(.N_OBS(2), .MIN_GAP(40), .GAP_RAND_W(0), .HIGH_EN(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate), .i_spawn_en(spawn_en),
    .i_speed(speed), .i_slowness(slowness), .o_active(b_act), .o_type(b_typ),
    .o_x1(b_x1), .o_x2(b_x2), .o_y1(b_y1), .o_y2(b_y2), .o_pass(b_pass));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] sl(input logic [35:0] v, input int k);
    return v[12*k +: 12];
  endfunction
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] s = 16'hACE1;
    for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
    return s;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    ani_stb = 1;
    repeat (n) step();
    ani_stb = 0;
  endtask
  initial begin
    logic [15:0] m;
    rst_n = 0;
    step();
    step();
    chk("rst_a_active", a_act, 0);
    chk("rst_a_x1", a_x1, 0);
    chk("rst_a_x2", a_x2, 0);
    chk("rst_a_y1", a_y1, 0);
    chk("rst_a_y2", a_y2, 0);
    chk("rst_a_pass", a_pass, 0);
    chk("rst_b_active", b_act, 0);
    chk("rst_b_y2", b_y2, 0);
    rst_n = 1; animate = 1; spawn_en = 1; speed = 1; slowness = 0;
    ticks(1);
    chk("t1_active", a_act, 3'b001);
    chk("t1_x1", sl(a_x1, 0), 600);
    chk("t1_x2", sl(a_x2, 0), 640);
    chk("t1_y1", sl(a_y1, 0), 280);
    chk("t1_y2", sl(a_y2, 0), 440);
    chk("t1_type_low", a_typ, 0);
    chk("t1_slot1_x1_idle", sl(a_x1, 1), 0);
    ticks(199);
    chk("t200_active", a_act, 3'b001);
    chk("t200_x1", sl(a_x1, 0), 401);
    ticks(1);
    chk("t201_active", a_act, 3'b011);
    chk("t201_s0_x1", sl(a_x1, 0), 400);
    chk("t201_s0_x2", sl(a_x2, 0), 440);
    chk("t201_s1_x1", sl(a_x1, 1), 600);
    ticks(399);
    chk("t600_active", a_act, 3'b111);
    chk("t600_s0_x1", sl(a_x1, 0), 1);
    ticks(1);
    chk("t601_active_full", a_act, 3'b111);
    chk("t601_s0_x1", sl(a_x1, 0), 0);
    chk("t601_s0_x2", sl(a_x2, 0), 40);
    chk("t601_pass", a_pass, 0);
    ticks(1);
    chk("t602_retired", a_act, 3'b110);
    chk("t602_pass", a_pass, 1);
    chk("t602_s0_x1", sl(a_x1, 0), 0);
    ticks(1);
    chk("t603_reuse", a_act, 3'b111);
    chk("t603_pass_low", a_pass, 0);
    chk("t603_s0_x1", sl(a_x1, 0), 600);
    speed = 2; slowness = 3;
    ticks(3);
    chk("slow3_s0_x1", sl(a_x1, 0), 600);
    chk("slow3_s1_x1", sl(a_x1, 1), 198);
    ticks(1);
    chk("slow4_s0_x1", sl(a_x1, 0), 598);
    chk("slow4_s1_x1", sl(a_x1, 1), 196);
    chk("slow4_s2_x1", sl(a_x1, 2), 396);
    animate = 0;
    ticks(4);
    chk("frozen_s0_x1", sl(a_x1, 0), 598);
    chk("frozen_s2_x1", sl(a_x1, 2), 396);
    animate = 1;
    ani_stb = 1; rst_n = 0;
    step();
    ani_stb = 0;
    chk("midrst_active", a_act, 0);
    chk("midrst_x1", a_x1, 0);
    chk("midrst_y2", a_y2, 0);
    chk("midrst_pass", a_pass, 0);
    rst_n = 1; speed = 4; slowness = 0;
    ticks(1);
    chk("b_t1_active", b_act, 2'b01);
    chk("b_t1_type", b_typ[0], 1);
    chk("b_t1_y1", sl({12'h0, b_y1}, 0), 280);
    chk("b_t1_y2", sl({12'h0, b_y2}, 0), 320);
    chk("b_t1_x1", sl({12'h0, b_x1}, 0), 600);
    ticks(10);
    m = lfsr_after(10);
    chk("b_t11_active", b_act, 2'b11);
    chk("b_t11_type", b_typ[1], m[15]);
    chk("b_t11_y2", sl({12'h0, b_y2}, 1), m[15] ? 320 : 440);
    ticks(10);
    chk("b_t21_full", b_act, 2'b11);
    ticks(130);
    chk("b_t151_active", b_act, 2'b11);
    chk("b_t151_x1", sl({12'h0, b_x1}, 0), 0);
    ticks(1);
    chk("b_t152_retired", b_act, 2'b10);
    chk("b_t152_pass", b_pass, 1);
    ticks(1);
    m = lfsr_after(152);
    chk("b_t153_respawn", b_act, 2'b11);
    chk("b_t153_pass", b_pass, 0);
    chk("b_t153_type", b_typ[0], m[15]);
    chk("b_t153_s0_x1", sl({12'h0, b_x1}, 0), 600);
    chk("b_t153_s1_x1", sl({12'h0, b_x1}, 1), 32);
    rst_n = 0;
    step();
    rst_n = 1; speed = 0;
    ticks(3);
    chk("spd0_active", a_act, 3'b001);
    chk("spd0_x1", sl(a_x1, 0), 600);
    ticks(300);
    chk("spd0_no_spawn", a_act, 3'b001);
    chk("spd0_still", sl(a_x1, 0), 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/obstacle_lane.md
Name: obstacle_lane

Overview:
- Multi-slot successor to the single scrolling obstacle. Manages N_OBS independent obstacles that scroll left across the play field.
- Each obstacle is either a ground ("low") type or an airborne ("high") type.
- Spawns obstacles pseudo-randomly with a minimum pixel gap, retires them at the left edge, and pulses a pass event for scoring.
- Feeds per-slot bounding boxes to the VGA renderer and the collision checker.

Parameters:
- N_OBS, 3, number of obstacle slots.
- H_WIDTH, 20, half width of every obstacle (px).
- H_HEIGHT_LOW, 80, half height of the low type.
- H_HEIGHT_HIGH, 20, half height of the high type.
- Y_HIGH, 300, vertical centre of the high type.
- BORDER, 40, ground margin. Low-type centre = D_HEIGHT-BORDER-H_HEIGHT_LOW.
- D_WIDTH, 640, display width.
- D_HEIGHT, 480, display height.
- SPD_W, 4, width of the speed input.
- SLOW_W, 4, width of the slowness input.
- MIN_GAP, 200, minimum scrolled pixels between spawns. Must be ≥ 2*H_WIDTH (elaboration check).
- GAP_RAND_W, 7, number of LFSR bits added to MIN_GAP as random extra gap. 0 means a fixed gap.
- HIGH_EN, 1, allow the high type.
- LFSR_SEED, 16'hACE1, LFSR seed. 0 is replaced by 16'hACE1.

Ports:
- i_clk, in, 1, base clock.
- i_rst_n, in, 1, synchronous active-low reset.
- i_ani_stb, in, 1, animation strobe (one cycle per frame).
- i_animate, in, 1, run enable. When low, all state freezes.
- i_spawn_en, in, 1, permit new spawns.
- i_speed, in, SPD_W, pixels moved per move tick.
- i_slowness, in, SLOW_W, strobes per move tick, minus 1.
- o_active, out, N_OBS, slot occupied.
- o_type, out, N_OBS, 0 = low, 1 = high.
- o_x1, o_x2, o_y1, o_y2, out, 12*N_OBS each, packed box edges. Slot k occupies bits [12k+11:12k].
- o_pass, out, 1, one-cycle pulse when an obstacle retires.

Behaviour:
- Reset (i_rst_n low at a clk edge) has priority over everything.
  - All slots inactive; o_pass=0; all box outputs 0.
  - Slowness count = 0.
  - gap_cnt saturated to all-ones, so the first eligible tick spawns.
  - gap_target = MIN_GAP.
  - LFSR = seed.
- Move tick = i_animate && i_ani_stb && (slow_cnt == i_slowness).
  - On a qualified strobe that is not a tick, slow_cnt increments.
  - On a tick, slow_cnt returns to 0.
  - i_animate low holds every register, including slow_cnt and the LFSR.
- On a move tick, evaluated against the pre-tick state:
  - Active slot with x < H_WIDTH+i_speed: retires. Slot becomes inactive and o_pass=1 in the next cycle.
  - Any other active slot: x <= x - i_speed (12-bit, speed zero-extended). There is no underflow by construction.
  - gap_cnt_next = gap_cnt + i_speed, saturating at 12-bit max.
  - Spawn when i_spawn_en && gap_cnt_next ≥ gap_target && some slot was free before the tick.
    - Target slot is the lowest-index free slot. x = D_WIDTH-H_WIDTH. The new slot does not move in its spawn tick.
    - Type = HIGH_EN ? lfsr[15] : 0.
    - gap_cnt <= 0.
    - gap_target <= MIN_GAP + lfsr[GAP_RAND_W-1:0].
  - A slot freed by retirement in this tick is not reused until the next tick.
  - If no spawn occurs, gap_cnt <= gap_cnt_next.
  - The LFSR advances once per tick (16-bit Galois, taps 16,14,13,11).
- i_speed = 0: nothing moves, gap does not grow, no new spawns. The saturated reset gap still allows the first spawn.
- Simultaneous retirements cannot occur, given shared speed and MIN_GAP ≥ 2*H_WIDTH. o_pass is a single pulse.
- Box outputs are registered (same cycle as the state):
  - x1 = x-H_WIDTH, x2 = x+H_WIDTH.
  - y1/y2 = y_centre ∓ half height of the slot's type.
  - Inactive slots output 0 on all four edges.

Decomposition:
- Package obstacle_pkg holds:
  - Display constants D_WIDTH, D_HEIGHT and BORDER.
  - The obstacle type encoding (LOW=0, HIGH=1).
  - The coordinate width of 12.
  - LFSR taps and the default seed.
- One sub-module, lfsr16: enable, seed load on reset, 16-bit state out.
- Slot logic uses a generate loop inside obstacle_lane. No per-slot sub-module.

Test Plan:
- Reset: hold i_rst_n=0 two cycles -> o_active=000, all edges 0, o_pass=0. Repeat with i_rst_n low mid-motion -> same result on the next edge.
- First spawn and gap (GAP_RAND_W=0, HIGH_EN=0, speed=1, slowness=0, spawn_en=1):
  - Tick 1 -> slot0 active, x1=600, x2=640, y1=280, y2=440.
  - Tick 201 -> slot1 spawns at x=620 while slot0 x=420.
- Slowness: i_slowness=3, speed=2 -> slot x drops by 2 only on every 4th strobe. With i_animate=0, strobes cause no change.
- Retire: slot at x=21, speed=1 -> next tick x=20. The following tick the slot goes inactive, o_pass high exactly one cycle, then a free slot is reused on a later tick.
- Full lane: N_OBS=2, MIN_GAP=40, speed=4 -> a third spawn is suppressed while both slots are active. gap_cnt keeps growing, and a spawn occurs on the first tick after a retirement.
- Types: HIGH_EN=1, seed 16'hACE1 -> the o_type sequence matches the reference-model LFSR bit 15. High slots show y1=280, y2=320.
